copy_pipe: RTL and testbench

COPY_PIPE -- requirements
Module: copy_pipe

---
 rtl/copy_pipe_pkg.sv | 16 +
 rtl/copy_pipe_mem.sv | 33 +++
 rtl/copy_pipe.sv | 83 ++++++++
 tb/tb_copy_pipe.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/copy_pipe_pkg.sv
// Shared constants for the copy_pipe FIFO: default sizes, legal ranges and a pointer-width helper.
package copy_pipe_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned WIDTH_MIN = 1;
  localparam int unsigned WIDTH_MAX = 64;
  localparam int unsigned DEPTH_MIN = 1;
  localparam int unsigned DEPTH_MAX = 16;

  // A single-entry buffer still needs a one-bit pointer.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/copy_pipe_mem.sv
// DEPTH x WIDTH register storage with one write port and one registered read port.
module copy_pipe_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Bypass covers an entry written this edge that is also the next head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/copy_pipe.sv
// Circular-buffer FIFO with valid/ready handshakes, registered head data and occupancy count.
module copy_pipe
  import copy_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  localparam int unsigned PW = ptr_w(DEPTH);

  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0] count_nxt;
  logic          push, pop;

  assign in_ready  = !flush && (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Next pointer/count; flush wins and discards any concurrent pop.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push) wr_ptr_nxt = ptr_inc(wr_ptr);
      if (pop)  rd_ptr_nxt = ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count_nxt = count + CW'(1);
        2'b01:   count_nxt = count - CW'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
    end
  end

  // Read port is addressed with the next head so out_data is registered yet current.
  copy_pipe_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr_nxt),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_copy_pipe.sv
// Scoreboard bench for copy_pipe: DEPTH=4 and DEPTH=3 instances against a queue model.
module tb_copy_pipe;

  logic clk = 1'b0;
  logic rst_n;

  logic       flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [2:0] count;

  logic       flush3, in_valid3, in_ready3, out_valid3, out_ready3;
  logic [7:0] in_data3, out_data3;
  logic [1:0] count3;

  int n_checks = 0;
  int n_errors = 0;
  int popped3  = 0;
  logic [7:0] q4[$];
  logic [7:0] q3[$];

  always #5 clk = ~clk;

  copy_pipe #(.WIDTH(8), .DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  copy_pipe #(.WIDTH(8), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush3), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .count(count3)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle on the DEPTH=4 instance; compare outputs against the model head first.
  task automatic step4(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    logic exp_rdy, do_push, do_pop;
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    #1;
    exp_rdy = !fl && (q4.size() < 4);
    check("d4_in_ready", 64'(in_ready), 64'(exp_rdy));
    check("d4_out_valid", 64'(out_valid), 64'(q4.size() != 0));
    check("d4_count", 64'(count), 64'(q4.size()));
    if (q4.size() != 0) check("d4_out_data", 64'(out_data), 64'(q4[0]));
    do_push = iv && exp_rdy;
    do_pop  = (q4.size() != 0) && ordy;
    @(posedge clk); #1;
    if (fl) q4.delete();
    else begin
      if (do_pop) void'(q4.pop_front());
      if (do_push) q4.push_back(d);
    end
  endtask

  task automatic step3(input logic iv, input logic [7:0] d, input logic ordy);
    logic exp_rdy, do_push, do_pop;
    in_valid3 = iv; in_data3 = d; out_ready3 = ordy; flush3 = 1'b0;
    #1;
    exp_rdy = (q3.size() < 3);
    check("d3_in_ready", 64'(in_ready3), 64'(exp_rdy));
    check("d3_out_valid", 64'(out_valid3), 64'(q3.size() != 0));
    check("d3_count", 64'(count3), 64'(q3.size()));
    if (q3.size() != 0) check("d3_out_data", 64'(out_data3), 64'(q3[0]));
    do_push = iv && exp_rdy;
    do_pop  = (q3.size() != 0) && ordy;
    @(posedge clk); #1;
    if (do_pop) begin void'(q3.pop_front()); popped3++; end
    if (do_push) q3.push_back(d);
  endtask

  initial begin
    int pushed3;
    rst_n = 1'b0;
    flush = 0; in_valid = 0; in_data = 0; out_ready = 0;
    flush3 = 0; in_valid3 = 0; in_data3 = 0; out_ready3 = 0;
    #12;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single push, then next-cycle visibility
    step4(1, 8'hA5, 0, 0);
    check("single_count", 64'(count), 64'd1);
    check("single_data", 64'(out_data), 64'hA5);
    step4(0, 0, 1, 0);

    // Fill to full, a fifth offer is refused, then drain in order
    for (int i = 1; i <= 4; i++) step4(1, 8'(i), 0, 0);
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    step4(1, 8'h55, 0, 0);
    for (int i = 0; i < 4; i++) step4(0, 0, 1, 0);
    check("drained_count", 64'(count), 64'd0);

    // Streaming: one entry resident, no stalls
    for (int i = 0; i < 100; i++) begin
      step4(1, 8'(8'h10 + i), 1, 0);
      check("stream_count", 64'(count), 64'd1);
    end
    step4(0, 0, 1, 0);

    // Flush with three held while the consumer is ready
    for (int i = 0; i < 3; i++) step4(1, 8'(8'hC0 + i), 0, 0);
    step4(1, 8'hEE, 1, 1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    step4(1, 8'h5A, 0, 0);
    check("post_flush_data", 64'(out_data), 64'h5A);
    step4(0, 0, 1, 0);

    // DEPTH=3 wrap with random back-pressure, bounded cycle budget
    pushed3 = 0;
    for (int cyc = 0; cyc < 300 && popped3 < 10; cyc++) begin
      logic iv;
      iv = (pushed3 < 10) && ($urandom_range(0, 3) != 0);
      if (iv && q3.size() < 3) begin
        step3(1, 8'(8'h80 + pushed3), 1'($urandom_range(0, 1)));
        pushed3++;
      end else begin
        step3(iv, 8'hFF, 1'($urandom_range(0, 1)));
      end
    end
    check("wrap_popped", 64'(popped3), 64'd10);

    // Asynchronous reset mid-stream, between edges
    step4(1, 8'h21, 0, 0);
    step4(1, 8'h22, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_data", 64'(out_data), 64'd0);
    q4.delete();
    q3.delete();
    in_valid = 0; out_ready = 0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    step4(1, 8'h77, 0, 0);
    check("resume_data", 64'(out_data), 64'h77);
    step4(1, 8'h78, 1, 0);
    step4(0, 0, 1, 0);
    step4(0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
